// File: rtl/cmp_pkg.sv
// Shared types and constants for the serial magnitude comparator.
package cmp_pkg;

   localparam int SLICE = 2;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
   } result_t;

endpackage

// File: rtl/serial_mag_compare_if.sv
// Start/operand/result bundle between a requester and the serial comparator.
interface serial_mag_compare_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             lt;
   logic             eq;
   logic             gt;

   modport master (output start, a, b, input busy, done, lt, eq, gt);
   modport slave  (input start, a, b, output busy, done, lt, eq, gt);
endinterface

// File: rtl/cmp2_slice.sv
// Combinational unsigned comparator for one 2-bit slice.
module cmp2_slice
   import cmp_pkg::*;
(
   input  logic [SLICE-1:0] x,
   input  logic [SLICE-1:0] y,
   output logic             lt,
   output logic             eq,
   output logic             gt
);

   assign lt = (x < y);
   assign eq = (x == y);
   assign gt = (x > y);

endmodule

// File: rtl/serial_mag_compare.sv
// MSB-first serial magnitude comparator, one 2-bit slice per clock with early exit.
//
// state | meaning
// IDLE  | waiting for start; results from the last scan held
// SCAN  | comparing the top slice of the shift registers each cycle
module serial_mag_compare
   import cmp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                 clock,
   input  logic                 reset,
   serial_mag_compare_if.slave  bus
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   sh_a, sh_a_nxt;
   logic [WIDTH-1:0]   sh_b, sh_b_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   result_t            res, res_nxt;
   logic               busy_q, busy_nxt;
   logic               done_q, done_nxt;

   logic               sl_lt, sl_eq, sl_gt;

   cmp2_slice u_slice (
      .x  (sh_a[WIDTH-1 -: SLICE]),
      .y  (sh_b[WIDTH-1 -: SLICE]),
      .lt (sl_lt),
      .eq (sl_eq),
      .gt (sl_gt)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         sh_a   <= '0;
         sh_b   <= '0;
         idx    <= '0;
         res    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         sh_a   <= sh_a_nxt;
         sh_b   <= sh_b_nxt;
         idx    <= idx_nxt;
         res    <= res_nxt;
         busy_q <= busy_nxt;
         done_q <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      sh_a_nxt  = sh_a;
      sh_b_nxt  = sh_b;
      idx_nxt   = idx;
      res_nxt   = res;
      busy_nxt  = busy_q;
      done_nxt  = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               sh_a_nxt  = bus.a;
               sh_b_nxt  = bus.b;
               idx_nxt   = '0;
               res_nxt   = '0;
               busy_nxt  = 1'b1;
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            if (!sl_eq) begin
               res_nxt   = '{lt: sl_lt, eq: 1'b0, gt: sl_gt};
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end else if (idx == LAST_IDX) begin
               res_nxt   = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};
               done_nxt  = 1'b1;
               busy_nxt  = 1'b0;
               state_nxt = IDLE;
            end else begin
               sh_a_nxt = sh_a << SLICE;
               sh_b_nxt = sh_b << SLICE;
               idx_nxt  = idx + IDX_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.lt   = res.lt;
   assign bus.eq   = res.eq;
   assign bus.gt   = res.gt;

endmodule

// File: tb/tb_serial_mag_compare.sv
// Self-checking bench for serial_mag_compare at WIDTH=8: vector table, corner sequences, random vs. model.
module tb_serial_mag_compare;

   localparam int W = 8;

   logic clock;
   logic reset;
   int   checks;
   int   failures;

   serial_mag_compare_if #(.WIDTH(W)) bus ();

   serial_mag_compare #(.WIDTH(W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0] va;
      logic [W-1:0] vb;
      logic [2:0]   res;   // {lt, eq, gt}
      int           lat;
   } vec_t;

   vec_t vecs[10];

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [2:0] outs();
      return {bus.lt, bus.eq, bus.gt};
   endfunction

   // Reference: result from plain unsigned arithmetic; the deciding slice is the
   // one holding the highest differing bit, or the last slice when equal.
   function automatic int model_lat(input logic [W-1:0] va, input logic [W-1:0] vb);
      logic [W-1:0] x;
      int p;
      x = va ^ vb;
      if (x == '0) return W / 2;
      p = 0;
      for (int i = 0; i < W; i++) if (x[i]) p = i;
      return (W - 1 - p) / 2 + 1;
   endfunction

   function automatic logic [2:0] model_res(input logic [W-1:0] va, input logic [W-1:0] vb);
      if (va < vb) return 3'b100;
      if (va == vb) return 3'b010;
      return 3'b001;
   endfunction

   // Issues start and waits for done; returns in the done cycle (1 tu after the edge).
   task automatic run_check(input string name, input logic [W-1:0] va, input logic [W-1:0] vb,
                            input logic [2:0] eres, input int elat);
      int  lat;
      bit  scan_ok;
      bus.a = va;
      bus.b = vb;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.a = ~va;
      bus.b = ~vb;
      lat = 0;
      scan_ok = 1'b1;
      while (!bus.done && lat < 20) begin
         if (!bus.busy || outs() != 3'b000) scan_ok = 1'b0;
         tick();
         lat++;
      end
      check({name, "_scan"}, 32'(scan_ok), 32'd1);
      check({name, "_lat"}, lat, elat);
      check({name, "_res"}, 32'(outs()), 32'(eres));
      check({name, "_busy_at_done"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0;
      failures = 0;
      bus.start = 1'b0;
      bus.a = '0;
      bus.b = '0;

      vecs[0] = '{8'hA5, 8'hA5, 3'b010, 4};
      vecs[1] = '{8'h80, 8'h7F, 3'b001, 1};
      vecs[2] = '{8'h34, 8'h36, 3'b100, 4};
      vecs[3] = '{8'h40, 8'h80, 3'b100, 1};
      vecs[4] = '{8'hC0, 8'h80, 3'b001, 1};
      vecs[5] = '{8'h00, 8'hFF, 3'b100, 1};
      vecs[6] = '{8'hFF, 8'hFE, 3'b001, 4};
      vecs[7] = '{8'h12, 8'h13, 3'b100, 4};
      vecs[8] = '{8'h0C, 8'h08, 3'b001, 3};
      vecs[9] = '{8'h00, 8'h00, 3'b010, 4};

      reset = 1'b1;
      tick();
      tick();
      check("reset_outs", 32'({bus.busy, bus.done, outs()}), 32'd0);
      reset = 1'b0;
      tick();
      check("idle_outs", 32'({bus.busy, bus.done, outs()}), 32'd0);

      // Table vectors, each followed by one idle cycle checking the pulse and hold.
      for (int i = 0; i < 10; i++) begin
         run_check($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].res, vecs[i].lat);
         tick();
         check($sformatf("vec%0d_done_pulse", i), 32'(bus.done), 32'd0);
         check($sformatf("vec%0d_hold", i), 32'(outs()), 32'(vecs[i].res));
      end

      // Results hold over 10 idle cycles.
      run_check("hold", 8'h34, 8'h36, 3'b100, 4);
      for (int i = 0; i < 10; i++) begin
         tick();
         check($sformatf("hold_c%0d", i), 32'({bus.busy, bus.done, outs()}), 32'b00100);
      end

      // start while busy is ignored.
      bus.a = 8'h00; bus.b = 8'h00; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      bus.a = 8'hFF; bus.b = 8'h00; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("ign_busy_e2", 32'({bus.busy, bus.done}), 32'b10);
      tick();
      check("ign_busy_e3", 32'({bus.busy, bus.done}), 32'b10);
      tick();
      check("ign_done_e4", 32'({bus.busy, bus.done, outs()}), 32'b01010);
      tick();
      check("ign_no_restart", 32'({bus.busy, bus.done}), 32'b00);

      // Back-to-back: start in the done cycle.
      run_check("b2b_first", 8'h40, 8'h80, 3'b100, 1);
      bus.a = 8'hC0; bus.b = 8'h80; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check("b2b_clear", 32'({bus.busy, bus.done, outs()}), 32'b10000);
      tick();
      check("b2b_second", 32'({bus.busy, bus.done, outs()}), 32'b01001);
      tick();

      // Asynchronous reset mid-scan.
      bus.a = 8'hA5; bus.b = 8'hA5; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      #2 reset = 1'b1;
      #1 check("rst_mid_outs", 32'({bus.busy, bus.done, outs()}), 32'd0);
      #2 reset = 1'b0;
      begin
         bit saw;
         saw = 1'b0;
         for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.done || bus.busy || outs() != 3'b000) saw = 1'b1;
         end
         check("rst_no_done", 32'(saw), 32'd0);
      end
      run_check("rst_after", 8'hA5, 8'hA5, 3'b010, 4);

      // Random operands against the arithmetic model, mixing idle gaps and back-to-back starts.
      for (int n = 0; n < 150; n++) begin
         logic [W-1:0] ra, rb;
         int mode;
         ra = W'($urandom);
         mode = $urandom_range(0, 3);
         if (mode == 0)      rb = ra;
         else if (mode == 1) rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
         else                rb = W'($urandom);
         run_check($sformatf("rnd%0d", n), ra, rb, model_res(ra, rb), model_lat(ra, rb));
         if ($urandom_range(0, 1) == 1) begin
            tick();
            check($sformatf("rnd%0d_hold", n), 32'({bus.done, outs()}), 32'({1'b0, model_res(ra, rb)}));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
